// File: rtl/edu_token_capture.sv
// edu_token_capture: two-stage registered token encoder with row well-formedness checks
// Ports:
//   clk, rst                       clock, asynchronous active-low reset
//   in_valid/in_ready              row handshake for token_set_row/flag_set_row
//   out_valid/out_ready            result handshake for token_exist_reg/token_col_reg
//   err_multi, err_flag, clr_err   sticky row errors and their clear pulse
//   tok_cnt                        saturating count of captured rows holding a token
module edu_token_capture #(
  parameter int NUM_UCROW = 4,
  parameter int CNT_W = 16,
  localparam int W = 2 * NUM_UCROW,
  localparam int CW = $clog2(NUM_UCROW) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     token_set_row,
  input  logic [W-1:0]     flag_set_row,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             token_exist_reg,
  output logic [CW-1:0]    token_col_reg,
  output logic             err_multi,
  output logic             err_flag,
  input  logic             clr_err,
  output logic [CNT_W-1:0] tok_cnt
);
  logic          r_s1_full;
  logic [W-1:0]  r_s1_tok, r_s1_flag;
  logic          w_acc, w_take, w_exist, w_multi;
  logic [CW-1:0] w_col;
  logic [W-1:0]  w_exp;
  assign in_ready = !r_s1_full || !out_valid || out_ready;
  assign w_acc = in_valid && in_ready;
  assign w_take = r_s1_full && (!out_valid || out_ready);
  assign w_exist = |r_s1_tok;
  assign w_multi = |(r_s1_tok & (r_s1_tok - 1'b1));
  // descending scan leaves the lowest set bit; expected flag is the thermometer up to it
  always_comb begin
    w_col = '0;
    w_exp = '0;
    for (int i = W - 1; i >= 0; i--) w_col = r_s1_tok[i] ? CW'(i) : w_col;
    for (int i = 0; i < W; i++) w_exp[i] = w_exist && (CW'(i) <= w_col);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1_full <= 1'b0;
      r_s1_tok <= '0;
      r_s1_flag <= '0;
      out_valid <= 1'b0;
      token_exist_reg <= 1'b0;
      token_col_reg <= '0;
      err_multi <= 1'b0;
      err_flag <= 1'b0;
      tok_cnt <= '0;
    end else begin
      if (w_acc) begin
        r_s1_full <= 1'b1;
        r_s1_tok <= token_set_row;
        r_s1_flag <= flag_set_row;
      end else if (w_take) begin
        r_s1_full <= 1'b0;
      end
      if (w_take) begin
        out_valid <= 1'b1;
        token_exist_reg <= w_exist;
        token_col_reg <= w_col;
        tok_cnt <= (w_exist && !(&tok_cnt)) ? tok_cnt + 1'b1 : tok_cnt;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      // a new error in the clearing cycle wins over the clear
      err_multi <= (err_multi && !clr_err) || (w_take && w_multi);
      err_flag <= (err_flag && !clr_err) || (w_take && (w_exp != r_s1_flag));
    end
  end
endmodule

// File: tb/tb_edu_token_capture.sv
// tb_edu_token_capture: randomized scoreboard bench for edu_token_capture
module tb_edu_token_capture;
  localparam int CNT_W = 4;
  logic clk = 1'b0, rst = 1'b0;
  logic in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
  logic [7:0] token_set_row = '0, flag_set_row = '0;
  logic token_exist_reg, err_multi, err_flag, clr_err = 1'b0;
  logic [2:0] token_col_reg;
  logic [CNT_W-1:0] tok_cnt;
  int n_chk = 0, n_fail = 0;
  typedef struct {logic [7:0] t; logic [7:0] f; int c;} row_t;
  row_t q[$];
  int cyc = 0, n_del = 0;
  bit seen = 0, m_em = 0, m_ef = 0;
  int m_cnt = 0;
  edu_token_capture #(.NUM_UCROW(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .token_set_row(token_set_row), .flag_set_row(flag_set_row),
    .out_valid(out_valid), .out_ready(out_ready),
    .token_exist_reg(token_exist_reg), .token_col_reg(token_col_reg),
    .err_multi(err_multi), .err_flag(err_flag), .clr_err(clr_err), .tok_cnt(tok_cnt));
  always #5 clk = ~clk;

  function automatic int m_col(logic [7:0] t);
    logic [7:0] lo;
    lo = t & (~t + 8'd1);
    return (t == 0) ? 0 : $clog2(lo);
  endfunction
  function automatic logic [7:0] m_flag(logic [7:0] t);
    int w;
    w = (t == 0) ? 0 : ((1 << (m_col(t) + 1)) - 1);
    return w[7:0];
  endfunction

  task automatic model_clear();
    q.delete();
    seen = 0; m_em = 0; m_ef = 0; m_cnt = 0;
  endtask

  task automatic step(input logic v, input logic [7:0] t, input logic [7:0] f,
                      input logic ordy, input logic clr, output bit acc);
    bit ev, er, del;
    row_t r;
    in_valid = v; token_set_row = t; flag_set_row = f; out_ready = ordy; clr_err = clr;
    #1;
    ev = q.size() > 0 && q[0].c < cyc;
    er = q.size() < 2 || ordy;
    n_chk++;
    if (in_ready !== er) begin n_fail++; $display("FAIL in_ready cyc=%0d got=%b exp=%b", cyc, in_ready, er); end
    acc = v && er;
    del = ev && ordy;
    @(posedge clk);
    #1;
    cyc++;
    if (del) begin q.pop_front(); n_del++; seen = 0; end
    if (acc) begin r.t = t; r.f = f; r.c = cyc; q.push_back(r); end
    if (clr) begin m_em = 0; m_ef = 0; end
    ev = q.size() > 0 && q[0].c < cyc;
    if (ev && !seen) begin
      seen = 1;
      if ($countones(q[0].t) > 1) m_em = 1;
      if (q[0].f != m_flag(q[0].t)) m_ef = 1;
      if (q[0].t != 0 && m_cnt < (1 << CNT_W) - 1) m_cnt++;
    end
    n_chk += 4;
    if (out_valid !== ev) begin n_fail++; $display("FAIL out_valid cyc=%0d got=%b exp=%b", cyc, out_valid, ev); end
    if (err_multi !== m_em) begin n_fail++; $display("FAIL err_multi cyc=%0d got=%b exp=%b", cyc, err_multi, m_em); end
    if (err_flag !== m_ef) begin n_fail++; $display("FAIL err_flag cyc=%0d got=%b exp=%b", cyc, err_flag, m_ef); end
    if (tok_cnt !== CNT_W'(m_cnt)) begin n_fail++; $display("FAIL tok_cnt cyc=%0d got=%0d exp=%0d", cyc, tok_cnt, m_cnt); end
    if (ev) begin
      n_chk += 2;
      if (token_exist_reg !== (q[0].t != 0)) begin n_fail++; $display("FAIL exist cyc=%0d row=%h got=%b", cyc, q[0].t, token_exist_reg); end
      if (token_col_reg !== 3'(m_col(q[0].t))) begin n_fail++; $display("FAIL col cyc=%0d row=%h got=%0d exp=%0d", cyc, q[0].t, token_col_reg, m_col(q[0].t)); end
    end
  endtask

  task automatic idle(input int n, input logic ordy);
    bit a;
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 8'h00, ordy, 1'b0, a);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; clr_err = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    model_clear();
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_chk += 3;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    if ({err_multi, err_flag, tok_cnt} !== '0) begin n_fail++; $display("FAIL reset_status got=%b%b/%0d exp=00/0", err_multi, err_flag, tok_cnt); end
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_basic();
    bit a;
    step(1'b1, 8'b0000_0100, 8'b0000_0111, 1'b1, 1'b0, a);
    n_chk++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_latency got=%b exp=0", out_valid); end
    step(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, a);
    n_chk++;
    if ({out_valid, token_exist_reg, token_col_reg, err_multi, err_flag, tok_cnt} !== {1'b1, 1'b1, 3'd2, 2'b00, CNT_W'(1)})
      begin n_fail++; $display("FAIL basic_row got=%b%b/%0d/%b%b/%0d exp=11/2/00/1", out_valid, token_exist_reg, token_col_reg, err_multi, err_flag, tok_cnt); end
    idle(1, 1'b1);
  endtask

  task automatic test_flag_err();
    bit a;
    step(1'b1, 8'h00, 8'h00, 1'b1, 1'b0, a);
    idle(1, 1'b1);
    n_chk++;
    if ({token_exist_reg, token_col_reg, err_flag, tok_cnt} !== {1'b0, 3'd0, 1'b0, CNT_W'(1)})
      begin n_fail++; $display("FAIL empty_row got=%b/%0d/%b/%0d exp=0/0/0/1", token_exist_reg, token_col_reg, err_flag, tok_cnt); end
    step(1'b1, 8'h00, 8'h01, 1'b1, 1'b0, a);
    idle(1, 1'b1);
    n_chk++;
    if (err_flag !== 1'b1) begin n_fail++; $display("FAIL stray_flag got=%b exp=1", err_flag); end
    step(1'b0, 8'h00, 8'h00, 1'b1, 1'b1, a);
  endtask

  task automatic test_edges();
    bit a;
    step(1'b1, 8'h80, 8'hFF, 1'b1, 1'b0, a);
    step(1'b1, 8'b0010_0100, 8'b0000_0111, 1'b1, 1'b0, a);
    n_chk++;
    if ({token_col_reg, err_multi, err_flag} !== {3'd7, 2'b00}) begin n_fail++; $display("FAIL top_col got=%0d/%b%b exp=7/00", token_col_reg, err_multi, err_flag); end
    idle(1, 1'b1);
    n_chk++;
    if ({token_col_reg, err_multi, err_flag} !== {3'd2, 2'b10}) begin n_fail++; $display("FAIL multi_tok got=%0d/%b%b exp=2/10", token_col_reg, err_multi, err_flag); end
    step(1'b0, 8'h00, 8'h00, 1'b1, 1'b1, a);
    n_chk++;
    if ({err_multi, err_flag} !== 2'b00) begin n_fail++; $display("FAIL clr_err got=%b%b exp=00", err_multi, err_flag); end
  endtask

  task automatic test_back_to_back();
    bit a, stall;
    int idx, d0;
    logic [7:0] t;
    idx = 0; d0 = n_del; stall = 0;
    for (int c = 1; c <= 16; c++) begin
      t = 8'(1 << (idx % 8));
      step(idx < 6, t, m_flag(t), !(c >= 2 && c <= 5), 1'b0, a);
      if (a) idx++;
      if (!in_ready) stall = 1;
    end
    n_chk += 2;
    if (!stall || idx != 6) begin n_fail++; $display("FAIL bp_stall stall=%b accepted=%0d exp=1/6", stall, idx); end
    if (n_del - d0 != 6 || q.size() != 0) begin n_fail++; $display("FAIL bp_delivered got=%0d exp=6", n_del - d0); end
  endtask

  task automatic test_saturation();
    bit a;
    int idx;
    logic [7:0] t;
    do_reset();
    idx = 0;
    while (idx < 17) begin
      t = 8'(1 << $urandom_range(7, 0));
      step(1'b1, t, m_flag(t), 1'b1, 1'b0, a);
      if (a) idx++;
    end
    idle(3, 1'b1);
    n_chk++;
    if (tok_cnt !== 4'd15) begin n_fail++; $display("FAIL saturate got=%0d exp=15", tok_cnt); end
  endtask

  task automatic test_random();
    bit a;
    logic [7:0] t, f;
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(3, 0))
        0: t = 8'h00;
        1, 2: t = 8'(1 << $urandom_range(7, 0));
        default: t = 8'($urandom);
      endcase
      f = ($urandom_range(2, 0) != 0) ? m_flag(t) : 8'($urandom);
      step($urandom_range(3, 0) != 0, t, f, $urandom_range(2, 0) != 0, $urandom_range(9, 0) == 0, a);
    end
    idle(3, 1'b1);
  endtask

  task automatic test_reset_mid();
    bit a;
    step(1'b1, 8'h11, 8'h00, 1'b0, 1'b0, a);
    step(1'b1, 8'h06, 8'h03, 1'b0, 1'b0, a);
    step(1'b1, 8'h01, 8'h01, 1'b0, 1'b0, a);
    rst = 1'b0;
    #1;
    n_chk++;
    if ({out_valid, err_multi, err_flag, tok_cnt} !== '0)
      begin n_fail++; $display("FAIL async_reset got=%b%b%b/%0d exp=000/0", out_valid, err_multi, err_flag, tok_cnt); end
    @(posedge clk); #2;
    rst = 1'b1;
    model_clear();
    idle(3, 1'b1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_flag_err();
    test_edges();
    test_back_to_back();
    test_saturation();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
